handshake_master_slave: RTL and testbench

Valid/ready point-to-point link of one source-side master and one sink-side slave sharing one clock. The master latches a byte from its local input, presents it on `data` with `valid`, and holds it until the slave accepts it. The slave advertises `ready_out` from an external readiness input and captures each accepted byte. It is the basic channel primitive for the AXI4-Lite channels and for standalone handshake checks.

---
 rtl/handshake_master_slave_if.sv | 8 +
 rtl/handshake_master_slave.sv | 58 +++++
 tb/tb_handshake_master_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/handshake_master_slave_if.sv
// handshake_master_slave_if: valid/data/ready link between the handshake master and slave
interface handshake_master_slave_if #(parameter int DATA_W = 8);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready_out;
    modport master(output valid, output data, input ready_out);
    modport slave(input valid, input data, output ready_out);
endinterface

// File: rtl/handshake_master_slave.sv
// handshake_master_slave: valid/ready byte link, master latches data_in, slave captures accepted bytes; HS_READY_REG_EN registers ready_out
module handshake_master_slave #(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       ready_in,
    handshake_master_slave_if.master   m,
    handshake_master_slave_if.slave    s,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_strobe,
    output logic [7:0]                 rx_count
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic              pend, m_xfer, s_xfer;
    assign pend    = |data_in;
    assign m_xfer  = m.valid & m.ready_out;
    assign m.valid = state == SEND;
    assign m.data  = data_q;
    // a zero data_in means nothing to send; a drained or empty slot refills from a nonzero one
    always_comb begin
        state_nx = state == IDLE ? (pend ? SEND : IDLE) : (m_xfer && !pend ? IDLE : SEND);
        data_nx  = (state == IDLE || m_xfer) && pend ? data_in : data_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            data_q <= data_nx;
        end
    end
`ifdef HS_READY_REG_EN
    logic ready_q;
    always_ff @(posedge clk) ready_q <= rst ? ready_in : 1'b0;
    assign s.ready_out = ready_q;
`else
    assign s.ready_out = ready_in & rst;
`endif
    assign s_xfer = s.valid & s.ready_out;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_strobe <= 1'b0;
            rx_count  <= '0;
        end else begin
            rx_strobe <= s_xfer;
            if (s_xfer) begin
                rx_data  <= s.data;
                rx_count <= rx_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_handshake_master_slave.sv
// tb_handshake_master_slave: vector table, corner sequences and random traffic against a slot-based reference model
module tb_handshake_master_slave;
    localparam int W = 8;
`ifdef HS_READY_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_in = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_strobe;
    logic [7:0]   rx_count;
    int n_chk = 0;
    int n_fail = 0;

    handshake_master_slave_if #(.DATA_W(W)) link();
    handshake_master_slave #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ready_in(ready_in),
        .m(link), .s(link),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_count(rx_count)
    );

    always #50 clk = ~clk;

    // reference model: one holding slot on the master side, a transfer log on the slave side
    bit         md_full = 0;
    logic [7:0] md_slot = 0;
    bit         md_rq = 0;
    bit         md_strobe = 0;
    logic [7:0] md_last = 0;
    int         md_total = 0;

    function automatic logic [7:0] md_cnt();
        return 8'(md_total % 256);
    endfunction

    function automatic void model_edge(input logic r, input logic [7:0] d, input logic ri);
        bit rdy, x;
        rdy = REG ? md_rq : (ri & r);
        x   = md_full & rdy;
        if (!r) begin
            md_full = 0; md_slot = 0; md_rq = 0; md_strobe = 0; md_last = 0; md_total = 0;
        end else begin
            md_strobe = x;
            if (x) begin
                md_last  = md_slot;
                md_total = md_total + 1;
            end
            if (!md_full || x) begin
                md_full = d != 0;
                if (d != 0) md_slot = d;
            end
            md_rq = ri;
        end
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic ri);
        rst = r; data_in = d; ready_in = ri;
        @(posedge clk);
        model_edge(r, d, ri);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 32'(link.valid), 32'(md_full));
        chk({tag, "_data"}, 32'(link.data), 32'(md_slot));
        chk({tag, "_ready"}, 32'(link.ready_out), 32'(REG ? md_rq : (ready_in & rst)));
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(md_last));
        chk({tag, "_strobe"}, 32'(rx_strobe), 32'(md_strobe));
        chk({tag, "_count"}, 32'(rx_count), 32'(md_cnt()));
    endtask

    typedef struct {
        logic       r;
        logic [7:0] d;
        logic       ri;
        logic       v;
        logic [7:0] dat;
        logic       ro;
        logic [7:0] rxd;
        logic       st;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[10];

    initial begin
        logic [7:0] c0;
        int t0, n;
        tbl[0] = '{1'b0, 8'h6B, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 8'h6B, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b0, 8'h00, 1'b0, 8'd0};
`ifdef HS_READY_REG_EN
        tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h6B, 1'b1, 8'h00, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h6B, 1'b0, 8'h6B, 1'b1, 8'd1};
        tbl[9] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'hCC, 1'b0, 8'hCC, 1'b1, 8'd4};
`else
        tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h6B, 1'b1, 8'h6B, 1'b1, 8'd1};
        tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h6B, 1'b0, 8'h6B, 1'b0, 8'd1};
        tbl[9] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hCC, 1'b0, 8'hCC, 1'b0, 8'd3};
`endif
        tbl[6] = '{1'b1, 8'hCC, 1'b1, 1'b1, 8'hCC, 1'b1, 8'h6B, 1'b0, 8'd1};
        tbl[7] = '{1'b1, 8'hCC, 1'b1, 1'b1, 8'hCC, 1'b1, 8'hCC, 1'b1, 8'd2};
        tbl[8] = '{1'b1, 8'hCC, 1'b1, 1'b1, 8'hCC, 1'b1, 8'hCC, 1'b1, 8'd3};
        #1;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].ri);
            chk($sformatf("vec%0d_valid", i), 32'(link.valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_data", i), 32'(link.data), 32'(tbl[i].dat));
            chk($sformatf("vec%0d_ready", i), 32'(link.ready_out), 32'(tbl[i].ro));
            chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(tbl[i].rxd));
            chk($sformatf("vec%0d_strobe", i), 32'(rx_strobe), 32'(tbl[i].st));
            chk($sformatf("vec%0d_count", i), 32'(rx_count), 32'(tbl[i].cnt));
        end
        // stall: slot holds 0xCC while data_in wanders and ready stays low
        step(1'b1, 8'hCC, 1'b0);
        c0 = md_cnt();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i[0] ? 8'h5A : 8'h00, 1'b0);
            chk("stall_data", 32'(link.data), 32'h CC);
            chk("stall_valid", 32'(link.valid), 32'd1);
            chk("stall_strobe", 32'(rx_strobe), 32'd0);
            chk("stall_count", 32'(rx_count), 32'(c0));
        end
        // glitch: ready_in pulse fully between edges
        rst = 1'b1; data_in = 8'h00; ready_in = 1'b0;
        #20 ready_in = 1'b1;
        #30 ready_in = 1'b0;
        step(1'b1, 8'h00, 1'b0);
        chk("glitch_valid", 32'(link.valid), 32'd1);
        chk("glitch_strobe", 32'(rx_strobe), 32'd0);
        chk("glitch_count", 32'(rx_count), 32'(c0));
        // ready_in high across one edge: exactly one transfer
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("span_count", 32'(rx_count), 32'(8'(c0 + 8'd1)));
        chk("span_rx_data", 32'(rx_data), 32'h CC);
        chk("span_valid", 32'(link.valid), 32'd0);
        chk("span_strobe", 32'(rx_strobe), 32'd0);
        // wrap: 256 transfers from reset bring rx_count back to 0
        step(1'b0, 8'h00, 1'b0);
        chk("wrap_reset_count", 32'(rx_count), 32'd0);
        t0 = md_total;
        n = 0;
        while (md_total - t0 < 256 && n < 600) begin
            step(1'b1, 8'($urandom_range(255, 1)), 1'b1);
            check_model("wrap");
            n++;
        end
        chk("wrap_xfers", 32'(md_total - t0), 32'd256);
        chk("wrap_count", 32'(rx_count), 32'd0);
        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       r, ri;
            logic [7:0] d;
            r  = $urandom_range(19, 0) != 0;
            d  = $urandom_range(1, 0) != 0 ? 8'($urandom) : 8'h00;
            ri = 1'($urandom);
            step(r, d, ri);
            check_model("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
